// File: rtl/seq_pkg.sv
// Shared definitions for the serializer / sequence-detector family:
// state encoding, idle line level and counter sizing.
package seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SHIFT  = 2'b01,
        S_PARITY = 2'b10,
        S_GAP    = 2'b11
    } seq_state_e;

    localparam logic IDLE_LEVEL = 1'b1;
    localparam int   GAP_CNT_W  = 4;

    // One extra bit so a count of exactly n is representable.
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/seq_ser_cnt.sv
// Loadable down-counter that saturates at zero; tc_o flags a zero count.
module seq_ser_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/seq_serializer.sv
// MSB-first parallel-to-serial framer with idle-high gap between frames.
// Define SEQ_SER_PARITY_EN to append an even-parity bit to every frame.
module seq_serializer #(
    parameter int DATA_W  = 8,
    parameter int GAP_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              seq,
    output logic              seq_vld,
    output logic              busy,
    output logic              done
);
    import seq_pkg::*;

    localparam int                   BIT_W      = cnt_w(DATA_W);
    localparam logic [BIT_W-1:0]     BIT_LOAD   = BIT_W'(DATA_W - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD   = GAP_CNT_W'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);
    localparam seq_state_e           POST_FRAME = (GAP_CYC == 0) ? S_IDLE : S_GAP;
`ifdef SEQ_SER_PARITY_EN
    localparam seq_state_e           AFTER_DATA = S_PARITY;
`else
    localparam seq_state_e           AFTER_DATA = POST_FRAME;
`endif

    seq_state_e        state_q;
    logic [DATA_W-1:0] shift_q;
`ifdef SEQ_SER_PARITY_EN
    logic              parity_q;
`endif

    logic handshake;
    logic frame_last;
    logic bit_tc;
    logic gap_tc;

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign handshake = in_valid && in_ready;
`ifdef SEQ_SER_PARITY_EN
    assign frame_last = (state_q == S_PARITY);
`else
    assign frame_last = (state_q == S_SHIFT) && bit_tc;
`endif

    seq_ser_cnt #(.W(BIT_W)) u_bit_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (handshake),
        .load_val_i (BIT_LOAD),
        .dec_i      (state_q == S_SHIFT),
        .tc_o       (bit_tc)
    );

    // Loaded on the last frame bit so the gap starts with its full count.
    seq_ser_cnt #(.W(GAP_CNT_W)) u_gap_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (frame_last && (GAP_CYC != 0)),
        .load_val_i (GAP_LOAD),
        .dec_i      (state_q == S_GAP),
        .tc_o       (gap_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
`ifdef SEQ_SER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (handshake) begin
                        shift_q  <= in_data;
`ifdef SEQ_SER_PARITY_EN
                        parity_q <= ^in_data;
`endif
                        state_q  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shift_q <= shift_q << 1;
                    if (bit_tc) begin
                        state_q <= AFTER_DATA;
                    end
                end
`ifdef SEQ_SER_PARITY_EN
                S_PARITY: state_q <= POST_FRAME;
`endif
                S_GAP: begin
                    if (gap_tc) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Outputs forced to idle values while reset is asserted.
    always_comb begin
        seq     = IDLE_LEVEL;
        seq_vld = 1'b0;
        busy    = 1'b0;
        if (!rst) begin
            case (state_q)
                S_SHIFT: begin
                    seq     = shift_q[DATA_W-1];
                    seq_vld = 1'b1;
                    busy    = 1'b1;
                end
`ifdef SEQ_SER_PARITY_EN
                S_PARITY: begin
                    seq     = parity_q;
                    seq_vld = 1'b1;
                    busy    = 1'b1;
                end
`endif
                S_GAP:   busy = 1'b1;
                default: ;
            endcase
        end
    end

    assign done = frame_last && !rst;

endmodule

// File: tb/tb_seq_serializer.sv
// Self-checking bench: table vectors, random frames against a frame-level
// reference model, plus back-to-back, mid-frame reset and zero-gap sequences.
module tb_seq_serializer;

    localparam int DW  = 8;
    localparam int GAP = 2;
`ifdef SEQ_SER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NF = DW + P;

    // Observed/expected vectors are packed {in_ready, seq, seq_vld, busy, done}.
    localparam logic [4:0] IDLE_OUT  = 5'b11000;
    localparam logic [4:0] RESET_OUT = 5'b01000;

    logic          clk = 1'b0;
    logic          rst;
    logic          vld_a, rdy_a, seq_a, sv_a, busy_a, done_a;
    logic [DW-1:0] dat_a;
    logic          vld_b, rdy_b, seq_b, sv_b, busy_b, done_b;
    logic [DW-1:0] dat_b;

    int n_tests = 0;
    int n_fail  = 0;

    seq_serializer #(.DATA_W(DW), .GAP_CYC(GAP)) dut (
        .clk(clk), .rst(rst), .in_valid(vld_a), .in_data(dat_a), .in_ready(rdy_a),
        .seq(seq_a), .seq_vld(sv_a), .busy(busy_a), .done(done_a)
    );

    seq_serializer #(.DATA_W(DW), .GAP_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(vld_b), .in_data(dat_b), .in_ready(rdy_b),
        .seq(seq_b), .seq_vld(sv_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] obs(input bit b);
        if (b) return {rdy_b, seq_b, sv_b, busy_b, done_b};
        return {rdy_a, seq_a, sv_a, busy_a, done_a};
    endfunction

    // Even parity = odd number of ones gives 1.
    function automatic logic ref_par(input logic [DW-1:0] w);
        int ones = 0;
        for (int i = 0; i < DW; i++) ones += int'(w[i]);
        return 1'((ones % 2));
    endfunction

    // Expected outputs k cycles after the handshake edge (k=0 is first data bit).
    function automatic logic [4:0] exp_at(input logic [DW-1:0] w, input logic par,
                                          input int k, input int gap);
        if (k < DW) return {1'b0, w[DW-1-k], 1'b1, 1'b1, 1'(k == NF - 1)};
        if (k < NF) return {1'b0, par, 1'b1, 1'b1, 1'b1};
        if (k < NF + gap) return 5'b01010;
        return IDLE_OUT;
    endfunction

    // Called at a negedge with dut idle; returns at a negedge with dut idle.
    task automatic run_frame(input logic [DW-1:0] w, input logic par, input string tag);
        chk({tag, " ready"}, 32'(rdy_a), 32'd1);
        vld_a = 1'b1;
        dat_a = w;
        @(negedge clk);
        for (int k = 0; k <= NF + GAP; k++) begin
            chk($sformatf("%s k%0d", tag, k), 32'(obs(0)), 32'(exp_at(w, par, k, GAP)));
            if (k < NF + GAP) begin
                vld_a = 1'($urandom);
                dat_a = DW'($urandom);
                @(negedge clk);
            end else begin
                vld_a = 1'b0;
            end
        end
        $display("[TB] %s word=%h parity=%b frame checked", tag, w, par);
    endtask

    typedef struct {
        logic [DW-1:0] data;
        logic          par;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int first_rdy;
        logic [DW-1:0] w;

        vecs[0] = '{8'hB4, 1'b0};
        vecs[1] = '{8'h07, 1'b1};
        vecs[2] = '{8'h00, 1'b0};
        vecs[3] = '{8'hFF, 1'b0};
        vecs[4] = '{8'h80, 1'b1};
        vecs[5] = '{8'h01, 1'b1};
        vecs[6] = '{8'hA5, 1'b0};
        vecs[7] = '{8'h3C, 1'b0};

        rst = 1'b1; vld_a = 1'b0; dat_a = '0; vld_b = 1'b0; dat_b = '0;
        repeat (2) @(negedge clk);
        chk("reset a", 32'(obs(0)), 32'(RESET_OUT));
        chk("reset b", 32'(obs(1)), 32'(RESET_OUT));
        $display("[TB] reset state checked");
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset a", 32'(obs(0)), 32'(IDLE_OUT));
        chk("post-reset b", 32'(obs(1)), 32'(IDLE_OUT));

        foreach (vecs[i]) run_frame(vecs[i].data, vecs[i].par, $sformatf("vec%0d", i));

        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            w = DW'($urandom);
            run_frame(w, ref_par(w), $sformatf("rnd%0d", i));
        end

        // in_valid held high: second handshake exactly one frame period later.
        vld_a = 1'b1; dat_a = 8'hA5;
        chk("b2b ready", 32'(rdy_a), 32'd1);
        @(negedge clk);
        dat_a = 8'h3C;
        first_rdy = -1;
        for (int k = 0; k <= NF + GAP; k++) begin
            chk($sformatf("b2b k%0d", k), 32'(obs(0)), 32'(exp_at(8'hA5, 1'b0, k, GAP)));
            if (rdy_a && first_rdy < 0) first_rdy = k;
            if (k < NF + GAP) @(negedge clk);
        end
        chk("b2b period", 32'(first_rdy + 1), 32'(1 + NF + GAP));
        @(negedge clk);
        vld_a = 1'b0;
        chk("b2b 2nd first bit", 32'(obs(0)), 32'(exp_at(8'h3C, 1'b0, 0, GAP)));
        repeat (NF + GAP) @(negedge clk);
        chk("b2b end idle", 32'(obs(0)), 32'(IDLE_OUT));
        $display("[TB] back-to-back A5,3C period=%0d", first_rdy + 1);

        // Reset on the 4th SHIFT cycle: frame abandoned, no done.
        vld_a = 1'b1; dat_a = 8'hC3;
        @(negedge clk);
        vld_a = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst-mid k3", 32'(obs(0)), 32'(exp_at(8'hC3, 1'b0, 3, GAP)));
        rst = 1'b1;
        @(negedge clk);
        chk("rst-mid in reset", 32'(obs(0)), 32'(RESET_OUT));
        rst = 1'b0;
        @(negedge clk);
        chk("rst-mid released", 32'(obs(0)), 32'(IDLE_OUT));
        for (int k = 0; k < NF + GAP; k++) begin
            @(negedge clk);
            chk($sformatf("rst-mid no resume k%0d", k), 32'(obs(0)), 32'(IDLE_OUT));
        end
        $display("[TB] mid-frame reset checked");
        run_frame(8'h5A, 1'b0, "post-rst");

        // Zero gap: 01 offered during the 80 frame, one IDLE cycle between.
        vld_b = 1'b1; dat_b = 8'h80;
        chk("gap0 ready", 32'(rdy_b), 32'd1);
        @(negedge clk);
        dat_b = 8'h01;
        for (int k = 0; k <= NF; k++) begin
            chk($sformatf("gap0 80 k%0d", k), 32'(obs(1)), 32'(exp_at(8'h80, 1'b1, k, 0)));
            if (k < NF) @(negedge clk);
        end
        @(negedge clk);
        vld_b = 1'b0;
        for (int k = 0; k <= NF; k++) begin
            chk($sformatf("gap0 01 k%0d", k), 32'(obs(1)), 32'(exp_at(8'h01, 1'b1, k, 0)));
            if (k < NF) @(negedge clk);
        end
        $display("[TB] zero-gap 80,01 sequence checked");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
